// File: rtl/counter32b_checker_pkg.sv
// Shared constants and types for the 32-bit counter checker.
package counter32b_checker_pkg;

    // Logic levels used by the counter family.
    localparam logic ALTO = 1'b1;
    localparam logic BAJO = 1'b0;

    localparam int unsigned MODO_W = 2;

    // Counter mode codes.
    typedef enum logic [MODO_W-1:0] {
        CUENTA_MAS_UNO   = 2'b00,
        CUENTA_MENOS_UNO = 2'b01,
        CUENTA_TRES_TRES = 2'b10,
        CARGA_D          = 2'b11
    } modo_e;

    // Checker FSM states.
    typedef enum logic [1:0] {
        CHK_IDLE  = 2'b00,
        CHK_ARM   = 2'b01,
        CHK_CHECK = 2'b10,
        CHK_FAIL  = 2'b11
    } chk_state_e;

endpackage

// File: rtl/counter32b_model.sv
// Cycle-accurate reference model of the 32-bit mode counter.
module counter32b_model
    import counter32b_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  d,
    input  logic [MODO_W-1:0] modo,
    output logic [WIDTH-1:0]  q,
    output logic              rco,
    output logic              load
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;
    logic [SUM_W-1:0] sum;

    // Next counter value and one-cycle rco/load pulses.
    always_comb begin
        q_next    = q;
        rco_next  = 1'b0;
        load_next = 1'b0;
        sum       = SUM_W'({1'b0, q}) + SUM_W'(3);
        if (enable == ALTO) begin
            case (modo_e'(modo))
                CUENTA_MAS_UNO: begin
                    q_next   = q + WIDTH'(1);
                    rco_next = (q == {WIDTH{1'b1}});
                end
                CUENTA_MENOS_UNO: begin
                    q_next   = q - WIDTH'(1);
                    rco_next = (q == '0);
                end
                CUENTA_TRES_TRES: begin
                    q_next   = sum[WIDTH-1:0];
                    rco_next = sum[WIDTH];
                end
                CARGA_D: begin
                    q_next    = d;
                    load_next = 1'b1;
                end
            endcase
        end
    end

    // Model registers share the counter's clock edge and synchronous reset.
    always_ff @(posedge clk) begin
        if (reset == BAJO) begin
            q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            q    <= q_next;
            rco  <= rco_next;
            load <= load_next;
        end
    end

endmodule

// File: rtl/counter32b_checker.sv
// Receive-side monitor: compares the counter's outputs against a reference model.
module counter32b_checker
    import counter32b_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ERR_W   = 16,
    parameter int unsigned MAX_ERR = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [WIDTH-1:0]  D,
    input  logic [MODO_W-1:0] MODO,
    input  logic [WIDTH-1:0]  Q_DUT,
    input  logic              RCO_DUT,
    input  logic              LOAD_DUT,
    input  logic              CLR_ERR,
    output logic              ERROR,
    output logic [ERR_W-1:0]  ERR_COUNT,
    output logic [31:0]       CHK_COUNT,
    output logic [WIDTH-1:0]  FIRST_EXP,
    output logic [WIDTH-1:0]  FIRST_GOT,
    output logic              FAIL
);

    chk_state_e       state;
    logic [WIDTH-1:0] q_m;
    logic             rco_m;
    logic             load_m;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_inc_c;

    counter32b_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk    (CLK),
        .reset  (RESET),
        .enable (ENABLE),
        .d      (D),
        .modo   (MODO),
        .q      (q_m),
        .rco    (rco_m),
        .load   (load_m)
    );

    // Per-cycle comparison and saturating error increment.
    always_comb begin
        mismatch_c = (q_m != Q_DUT) || (rco_m != RCO_DUT) || (load_m != LOAD_DUT);
        err_inc_c  = (ERR_COUNT == {ERR_W{1'b1}}) ? ERR_COUNT : ERR_COUNT + ERR_W'(1);
    end

    // Checker FSM with counters and first-failure capture.
    always_ff @(posedge CLK) begin
        if (RESET == BAJO) begin
            state     <= CHK_IDLE;
            ERROR     <= 1'b0;
            ERR_COUNT <= '0;
            CHK_COUNT <= '0;
            FIRST_EXP <= '0;
            FIRST_GOT <= '0;
            FAIL      <= 1'b0;
        end else begin
            case (state)
                CHK_IDLE: state <= CHK_ARM;
                // Skip one edge so model and counter both leave reset together.
                CHK_ARM: state <= CHK_CHECK;
                CHK_CHECK: begin
                    CHK_COUNT <= CHK_COUNT + 32'd1;
                    if (CLR_ERR == ALTO) begin
                        ERROR     <= 1'b0;
                        ERR_COUNT <= '0;
                        FIRST_EXP <= '0;
                        FIRST_GOT <= '0;
                    end else if (mismatch_c) begin
                        ERROR     <= 1'b1;
                        ERR_COUNT <= err_inc_c;
                        if (ERROR == BAJO) begin
                            FIRST_EXP <= q_m;
                            FIRST_GOT <= Q_DUT;
                        end
                        if (err_inc_c == ERR_W'(MAX_ERR)) begin
                            state <= CHK_FAIL;
                            FAIL  <= 1'b1;
                        end
                    end
                end
                CHK_FAIL: begin
                    if (CLR_ERR == ALTO) begin
                        state     <= CHK_CHECK;
                        FAIL      <= 1'b0;
                        ERROR     <= 1'b0;
                        ERR_COUNT <= '0;
                        FIRST_EXP <= '0;
                        FIRST_GOT <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter32b_checker.sv
// Self-checking bench for counter32b_checker: plays a correct (or corrupted) counter.
module tb_counter32b_checker;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned MAX_ERR = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             ENABLE;
    logic [WIDTH-1:0] D;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] Q_DUT;
    logic             RCO_DUT;
    logic             LOAD_DUT;
    logic             CLR_ERR;
    logic             ERROR;
    logic [ERR_W-1:0] ERR_COUNT;
    logic [31:0]      CHK_COUNT;
    logic [WIDTH-1:0] FIRST_EXP;
    logic [WIDTH-1:0] FIRST_GOT;
    logic             FAIL;

    always #5 CLK = ~CLK;

    counter32b_checker #(
        .WIDTH   (WIDTH),
        .ERR_W   (ERR_W),
        .MAX_ERR (MAX_ERR)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .D         (D),
        .MODO      (MODO),
        .Q_DUT     (Q_DUT),
        .RCO_DUT   (RCO_DUT),
        .LOAD_DUT  (LOAD_DUT),
        .CLR_ERR   (CLR_ERR),
        .ERROR     (ERROR),
        .ERR_COUNT (ERR_COUNT),
        .CHK_COUNT (CHK_COUNT),
        .FIRST_EXP (FIRST_EXP),
        .FIRST_GOT (FIRST_GOT),
        .FAIL      (FAIL)
    );

    int checks = 0;
    int errors = 0;

    // Ideal counter state (what a correct counter presents).
    logic [31:0] cq    = '0;
    logic        crco  = 1'b0;
    logic        cload = 1'b0;

    // Expected checker observables.
    int          since   = 0;
    bit          failing = 1'b0;
    logic [31:0] e_chk   = '0;
    int          e_err   = 0;
    logic        e_error = 1'b0;
    logic [31:0] e_fe    = '0;
    logic [31:0] e_fg    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".error"},     32'(ERROR),     32'(e_error));
        check({tag, ".err_count"}, 32'(ERR_COUNT), 32'(e_err));
        check({tag, ".chk_count"}, CHK_COUNT,      e_chk);
        check({tag, ".first_exp"}, FIRST_EXP,      e_fe);
        check({tag, ".first_got"}, FIRST_GOT,      e_fg);
        check({tag, ".fail"},      32'(FAIL),      32'(failing));
    endtask

    task automatic clear_expect();
        e_error = 1'b0;
        e_err   = 0;
        e_fe    = '0;
        e_fg    = '0;
    endtask

    // One clock: present counter outputs (optionally corrupted), predict, clock, check.
    task automatic cycle(input string tag, input logic rst, input logic en, input logic [1:0] modo,
                         input logic [31:0] d, input logic clr, input logic [31:0] qf,
                         input logic rf, input logic lf);
        logic   mism;
        longint s;
        RESET    = rst;
        ENABLE   = en;
        MODO     = modo;
        D        = d;
        CLR_ERR  = clr;
        Q_DUT    = cq ^ qf;
        RCO_DUT  = crco ^ rf;
        LOAD_DUT = cload ^ lf;
        mism     = (qf != '0) || rf || lf;

        if (!rst) begin
            since   = 0;
            failing = 1'b0;
            e_chk   = '0;
            clear_expect();
        end else begin
            if (failing) begin
                if (clr) begin
                    failing = 1'b0;
                    clear_expect();
                end
            end else if (since >= 2) begin
                e_chk = e_chk + 32'd1;
                if (clr) begin
                    clear_expect();
                end else if (mism) begin
                    if (!e_error) begin
                        e_fe = cq;
                        e_fg = cq ^ qf;
                    end
                    e_error = 1'b1;
                    if (e_err < 65535) e_err++;
                    if (e_err == int'(MAX_ERR)) failing = 1'b1;
                end
            end
            if (since < 2) since++;
        end

        if (!rst) begin
            cq = '0; crco = 1'b0; cload = 1'b0;
        end else if (!en) begin
            crco = 1'b0; cload = 1'b0;
        end else begin
            cload = 1'b0;
            case (modo)
                2'd0: begin crco = (cq == 32'hFFFF_FFFF); cq = cq + 32'd1; end
                2'd1: begin crco = (cq == 32'h0);         cq = cq - 32'd1; end
                2'd2: begin
                    s    = longint'(cq) + 64'd3;
                    crco = (s > 64'h0000_0000_FFFF_FFFF);
                    cq   = 32'(s);
                end
                default: begin cq = d; cload = 1'b1; crco = 1'b0; end
            endcase
        end

        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] one_bit();
        logic [31:0] b;
        b = 32'd1;
        return b << $urandom_range(31, 0);
    endfunction

    function automatic logic [31:0] pick_d();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFE;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        RESET = 1'b0; ENABLE = 1'b0; D = '0; MODO = 2'b00;
        Q_DUT = '0; RCO_DUT = 1'b0; LOAD_DUT = 1'b0; CLR_ERR = 1'b0;

        // 1: reset, then a clean up-count.
        for (int i = 0; i < 3; i++) cycle("s1_rst", 1'b0, 1'b1, 2'b00, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cycle("s1_up", 1'b1, 1'b1, 2'b00, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        check("s1_chk19", CHK_COUNT, 32'd19);
        check("s1_noerr", 32'(ERROR), 32'd0);

        // 2: +3 wrap from FFFFFFFE, then an RCO held one cycle too long.
        cycle("s2_load", 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFE, 1'b0, '0, 1'b0, 1'b0);
        cycle("s2_p3",   1'b1, 1'b1, 2'b10, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        cycle("s2_rco",  1'b1, 1'b0, 2'b00, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        check("s2_clean", 32'(ERR_COUNT), 32'd0);
        cycle("s2_hold", 1'b1, 1'b0, 2'b00, $urandom(), 1'b0, '0, 1'b1, 1'b0);
        check("s2_err1", 32'(ERR_COUNT), 32'd1);
        check("s2_wrapq", FIRST_EXP, 32'h0000_0001);
        cycle("s2_clr",  1'b1, 1'b0, 2'b00, $urandom(), 1'b1, '0, 1'b0, 1'b0);

        // 3: first-failure capture, not overwritten by a later mismatch.
        cycle("s3_load", 1'b1, 1'b1, 2'b11, 32'd3, 1'b0, '0, 1'b0, 1'b0);
        cycle("s3_inc",  1'b1, 1'b1, 2'b00, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        cycle("s3_bad",  1'b1, 1'b0, 2'b00, $urandom(), 1'b0, 32'd1, 1'b0, 1'b0);
        check("s3_exp", FIRST_EXP, 32'd4);
        check("s3_got", FIRST_GOT, 32'd5);
        cycle("s3_bad2", 1'b1, 1'b0, 2'b00, $urandom(), 1'b0, 32'h10, 1'b0, 1'b0);
        check("s3_exp2", FIRST_EXP, 32'd4);
        check("s3_got2", FIRST_GOT, 32'd5);

        // 4: MAX_ERR mismatches -> FAIL, frozen until cleared.
        cycle("s4_clr", 1'b1, 1'b1, 2'b00, $urandom(), 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cycle("s4_inj", 1'b1, 1'($urandom_range(0, 1)), 2'b00, $urandom(), 1'b0,
                  one_bit(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("s4_fail", 32'(FAIL), 32'd1);
        check("s4_err8", 32'(ERR_COUNT), 32'd8);
        for (int i = 0; i < 3; i++)
            cycle("s4_frz", 1'b1, 1'b1, 2'b00, $urandom(), 1'b0, one_bit(), 1'b0, 1'b0);
        check("s4_err8f", 32'(ERR_COUNT), 32'd8);
        cycle("s4_exit", 1'b1, 1'b1, 2'b00, $urandom(), 1'b1, '0, 1'b0, 1'b0);
        check("s4_cleared", 32'(ERR_COUNT), 32'd0);
        check("s4_nofail", 32'(FAIL), 32'd0);
        cycle("s4_again", 1'b1, 1'b1, 2'b00, $urandom(), 1'b0, one_bit(), 1'b0, 1'b0);
        check("s4_recheck", 32'(ERR_COUNT), 32'd1);

        // 5: -1 wrap from 0, then hold with enable low.
        cycle("s5_clr",  1'b1, 1'b1, 2'b00, $urandom(), 1'b1, '0, 1'b0, 1'b0);
        cycle("s5_load", 1'b1, 1'b1, 2'b11, 32'd0, 1'b0, '0, 1'b0, 1'b0);
        cycle("s5_m1",   1'b1, 1'b1, 2'b01, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle("s5_hold", 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom(), 1'b0,
                  (i == 2) ? 32'd1 : 32'd0, 1'b0, 1'b0);
        check("s5_exp", FIRST_EXP, 32'hFFFF_FFFF);
        check("s5_got", FIRST_GOT, 32'hFFFF_FFFE);
        check("s5_err1", 32'(ERR_COUNT), 32'd1);

        // 6: reset with an error pending and CLR_ERR asserted; ARM not counted.
        cycle("s6_rst", 1'b0, 1'b1, 2'b00, $urandom(), 1'b1, one_bit(), 1'b1, 1'b0);
        check("s6_err0", 32'(ERROR), 32'd0);
        check("s6_chk0", CHK_COUNT, 32'd0);
        for (int i = 0; i < 3; i++) cycle("s6_rel", 1'b1, 1'b1, 2'b10, $urandom(), 1'b0, '0, 1'b0, 1'b0);
        check("s6_chk1", CHK_COUNT, 32'd1);

        // Random traffic with occasional corruption, clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic        bad;
            logic [31:0] qf;
            bad = ($urandom_range(0, 7) == 0);
            qf  = (bad && $urandom_range(0, 1) == 1) ? one_bit() : 32'd0;
            cycle("rnd", 1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), pick_d(), 1'($urandom_range(0, 29) == 0),
                  qf, bad && (qf == '0) && ($urandom_range(0, 1) == 1),
                  bad && (qf == '0) && ($urandom_range(0, 1) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
